router_input_fifo: RTL and testbench
====================================

ROUTER_INPUT_FIFO -- requirements
Module: router_input_fifo

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of flit entries; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 4, destination-address width; X in the low half, Y in the high half.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, upstream flit valid this cycle.
REQ-007 SHALL have port flit_in, input, FLIT_W, incoming flit.
REQ-008 SHALL have port rd_en, input, 1, switch allocator pops the head flit.
REQ-009 SHALL have port flit_out, output, FLIT_W, head flit (first-word fall-through).
REQ-010 SHALL have port flit_type, output, 3, flit_out[FLIT_W-1:FLIT_W-3].
REQ-011 SHALL have port dst_addr, output, ADDR_W, flit_out[FLIT_W-4:FLIT_W-3-ADDR_W].
REQ-012 SHALL have port empty, output, 1, no flit stored.
REQ-013 SHALL have port full, output, 1, DEPTH flits stored.
REQ-014 SHALL have port credit_out, output, 1, one-cycle pulse returning one buffer credit upstream.
REQ-015 SHALL have port overflow_err, output, 1, sticky error flag; exists only when the macro in REQ-036 is defined.

Function
REQ-016 SHALL implement a circular buffer with write pointer, read pointer and occupancy counter; occupancy is $clog2(DEPTH)+1 bits wide.
REQ-017 SHALL accept a write when valid_in=1 and full=0, storing flit_in at the write pointer on that clock edge.
REQ-018 SHALL accept a read when rd_en=1 and empty=0, advancing the read pointer on that clock edge.
REQ-019 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-020 SHALL register empty and full and derive both from the next-state occupancy, with no combinational path from inputs.
REQ-021 SHALL deassert empty in the cycle after the first accepted write into an empty FIFO; flit_out is valid in that same cycle.
REQ-022 SHALL drive flit_out, flit_type and dst_addr combinationally from the entry at the read pointer; these are don't-care while empty=1.
REQ-023 SHALL, on a simultaneous accepted read and accepted write, leave the occupancy unchanged and move both pointers.
REQ-024 SHALL, when full=1 and rd_en=1 with valid_in=1 in the same cycle, accept the read only; the write is dropped, because full is evaluated before the read.
REQ-025 SHALL ignore rd_en while empty=1, leaving the pointers and occupancy unchanged.
REQ-026 SHALL ignore a write attempt while full=1, leaving the storage unchanged.
REQ-027 SHALL register credit_out high for exactly one cycle, in the cycle following each accepted read.
REQ-028 SHALL keep each flit unchanged while it is buffered, so HEADER/BODY/TAIL order is preserved end to end.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set the pointers and occupancy to 0, empty=1, full=0 and credit_out=0.
REQ-030 SHALL give rst priority over any write or read in the same cycle.
REQ-031 SHALL discard stored flits on reset mid-packet; the storage array itself is not cleared.
REQ-032 SHALL clear overflow_err to 0 on reset when it is compiled in.

Configuration
REQ-033 SHALL, with ROUTER_FIFO_OVF_DETECT_EN defined, provide overflow_err.
REQ-034 SHALL set overflow_err to 1 on the clock edge after any cycle with valid_in=1 and full=1, and hold it until rst.
REQ-035 SHALL, without ROUTER_FIFO_OVF_DETECT_EN, omit overflow_err and its logic entirely; all other behaviour is identical.
REQ-036 SHALL use the macro name ROUTER_FIFO_OVF_DETECT_EN exactly.

Verification
REQ-037 SHALL cover: reset, then one write of 0xA1234567 -> empty=0 in the next cycle, flit_out=0xA1234567, flit_type=3'b101, dst_addr=4'h0.
REQ-038 SHALL cover: 4 back-to-back writes with DEPTH=4 and no reads -> full=1 after the 4th write; a 5th write is dropped and, with the macro defined, overflow_err=1 on the following edge.
REQ-039 SHALL cover: FIFO full, then rd_en=1 and valid_in=1 together -> occupancy becomes 3, full=0, credit_out pulses once, and the new flit is not stored.
REQ-040 SHALL cover: 10 writes interleaved with reads across pointer wrap -> output order equals input order and credit_out pulses total 10.
REQ-041 SHALL cover: rd_en=1 while empty -> no pointer change and credit_out stays 0.
REQ-042 SHALL cover: rst asserted with 2 flits stored and valid_in=1 -> empty=1, full=0, credit_out=0 and overflow_err=0 after the edge.

Source files
------------

// File: rtl/router_input_fifo.sv
// -----------------------------------------------------------------------------
// router_input_fifo
//
// Purpose:
//   Input buffer for one router port. It is a circular buffer of DEPTH flits
//   with first-word fall-through: the head flit is always visible on flit_out.
//   The type and destination fields of the head flit are decoded alongside it.
//   Every flit popped by the switch allocator returns one credit upstream
//   through a one-cycle credit_out pulse.
//
// Parameters:
//   FLIT_W  flit width in bits (default 32)
//   DEPTH   number of flit entries; must be a power of two, at least 2
//   ADDR_W  destination address width; X in the low half, Y in the high half
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   valid_in      upstream flit valid this cycle
//   flit_in       incoming flit
//   rd_en         switch allocator pops the head flit
//   flit_out      head flit (don't-care while empty)
//   flit_type     flit_out[FLIT_W-1:FLIT_W-3]
//   dst_addr      flit_out[FLIT_W-4:FLIT_W-3-ADDR_W]
//   empty         no flit stored (registered)
//   full          DEPTH flits stored (registered)
//   credit_out    one-cycle pulse after each accepted read
//   overflow_err  sticky flag, set after a write attempt while full
//
// Build option:
//   ROUTER_FIFO_OVF_DETECT_EN  when defined, adds overflow_err and its logic.
// -----------------------------------------------------------------------------
module router_input_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] flit_out,
  output logic [2:0]        flit_type,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              empty,
  output logic              full,
  output logic              credit_out
`ifdef ROUTER_FIFO_OVF_DETECT_EN
  ,
  output logic              overflow_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Storage is never reset: a reset only discards the contents logically by
  // clearing the pointers and occupancy.
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             credit_q, credit_d;

  logic wr_accept;
  logic rd_accept;

  // Acceptance uses the registered flags only, so a write into a full FIFO is
  // dropped even when a read frees an entry in the same cycle.
  assign wr_accept = valid_in & ~full_q;
  assign rd_accept = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so the natural pointer rollover is the wrap.
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags come from the next-state occupancy so they are valid in the cycle
    // right after the edge that changes it.
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    credit_d = rd_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      credit_q <= credit_d;
    end
  end

  // A write cycle coinciding with reset must not land in the array.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= flit_in;
    end
  end

`ifdef ROUTER_FIFO_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (valid_in & full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_err = ovf_q;
`endif

  // Fall-through head and its decoded header fields.
  assign flit_out   = mem_q[rd_ptr_q];
  assign flit_type  = flit_out[FLIT_W-1 -: 3];
  assign dst_addr   = flit_out[FLIT_W-4 -: ADDR_W];
  assign empty      = empty_q;
  assign full       = full_q;
  assign credit_out = credit_q;

endmodule

// File: tb/tb_router_input_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_input_fifo
//
// Self-checking bench for router_input_fifo (FLIT_W=32, DEPTH=4, ADDR_W=4).
// A directed vector table comes first, followed by a pointer-wrap ordering
// sequence and then a randomized run checked against a queue-based model.
// -----------------------------------------------------------------------------
module tb_router_input_fifo;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              valid_in;
  logic [FLIT_W-1:0] flit_in;
  logic              rd_en;
  logic [FLIT_W-1:0] flit_out;
  logic [2:0]        flit_type;
  logic [ADDR_W-1:0] dst_addr;
  logic              empty;
  logic              full;
  logic              credit_out;
`ifdef ROUTER_FIFO_OVF_DETECT_EN
  logic              overflow_err;
`endif

  router_input_fifo #(
    .FLIT_W(FLIT_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .flit_in     (flit_in),
    .rd_en       (rd_en),
    .flit_out    (flit_out),
    .flit_type   (flit_type),
    .dst_addr    (dst_addr),
    .empty       (empty),
    .full        (full),
    .credit_out  (credit_out)
`ifdef ROUTER_FIFO_OVF_DETECT_EN
    ,
    .overflow_err(overflow_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO contents as a plain queue of flits.
  // ---------------------------------------------------------------------------
  logic [31:0] mq[$];
  logic        m_credit = 1'b0;
  logic        m_ovf    = 1'b0;

  task automatic model_edge(input logic r, input logic v, input logic rd,
                            input logic [31:0] f);
    int n;
    bit wr_ok;
    bit rd_ok;
    logic [31:0] dump;
    if (r) begin
      mq.delete();
      m_credit = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      n     = mq.size();
      wr_ok = v && (n < DEPTH);
      rd_ok = rd && (n > 0);
      if (v && n == DEPTH) m_ovf = 1'b1;
      m_credit = rd_ok;
      if (rd_ok) dump = mq.pop_front();
      if (wr_ok) mq.push_back(f);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, settle.
  task automatic cycle(input logic r, input logic v, input logic rd,
                       input logic [31:0] f);
    rst      = r;
    valid_in = v;
    rd_en    = rd;
    flit_in  = f;
    @(posedge clk);
    model_edge(r, v, rd, f);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] head;
    chk({tag, ".empty"},  32'(empty),      32'(mq.size() == 0));
    chk({tag, ".full"},   32'(full),       32'(mq.size() == DEPTH));
    chk({tag, ".credit"}, 32'(credit_out), 32'(m_credit));
    if (mq.size() > 0) begin
      head = mq[0];
      chk({tag, ".flit"},  flit_out,        head);
      chk({tag, ".type"},  32'(flit_type),  (head >> 29) & 32'h7);
      chk({tag, ".dst"},   32'(dst_addr),   (head >> 25) & 32'hF);
    end
`ifdef ROUTER_FIFO_OVF_DETECT_EN
    chk({tag, ".ovf"},    32'(overflow_err), 32'(m_ovf));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic        v;
    logic        rd;
    logic [31:0] f;
    logic        e_empty;
    logic        e_full;
    logic        e_credit;
    logic        chk_flit;
    logic [31:0] e_flit;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic rd,
                              input logic [31:0] f, input logic ee,
                              input logic ef, input logic ec, input logic cf,
                              input logic [31:0] exf);
    vec_t t;
    t.r = r; t.v = v; t.rd = rd; t.f = f;
    t.e_empty = ee; t.e_full = ef; t.e_credit = ec;
    t.chk_flit = cf; t.e_flit = exf;
    return t;
  endfunction

  localparam int NV = 18;
  vec_t tv[NV];

  logic [31:0] sent[$];
  logic [31:0] got[$];
  int          credits;
  bit          do_rd;
  bit          v_r, rd_r, rst_r;

  initial begin
    rst = 1'b1; valid_in = 1'b0; rd_en = 1'b0; flit_in = '0;

    //              rst   valid rd    flit_in        empty full  credit chkf  exp flit_out
    tv[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[1]  = mk(1'b0, 1'b1, 1'b0, 32'hA123_4567, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA123_4567);
    tv[2]  = mk(1'b0, 1'b1, 1'b0, 32'h2000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA123_4567);
    tv[3]  = mk(1'b0, 1'b1, 1'b0, 32'h4000_0002, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA123_4567);
    tv[4]  = mk(1'b0, 1'b1, 1'b0, 32'h6000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA123_4567);
    tv[5]  = mk(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA123_4567);
    tv[6]  = mk(1'b0, 1'b1, 1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000_0001);
    tv[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0001);
    tv[8]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4000_0002);
    tv[9]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h6000_0003);
    tv[10] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tv[11] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[12] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[13] = mk(1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    tv[14] = mk(1'b0, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    tv[15] = mk(1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[16] = mk(1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tv[17] = mk(1'b0, 1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444);

    for (int i = 0; i < NV; i++) begin
      cycle(tv[i].r, tv[i].v, tv[i].rd, tv[i].f);
      $display("vec %0d: rst=%b valid=%b rd=%b in=%h -> empty=%b full=%b credit=%b out=%h",
               i, tv[i].r, tv[i].v, tv[i].rd, tv[i].f, empty, full, credit_out, flit_out);
      chk($sformatf("vec%0d.empty", i),  32'(empty),      32'(tv[i].e_empty));
      chk($sformatf("vec%0d.full", i),   32'(full),       32'(tv[i].e_full));
      chk($sformatf("vec%0d.credit", i), 32'(credit_out), 32'(tv[i].e_credit));
      if (tv[i].chk_flit) begin
        chk($sformatf("vec%0d.flit", i), flit_out,        tv[i].e_flit);
        chk($sformatf("vec%0d.type", i), 32'(flit_type),  (tv[i].e_flit >> 29) & 32'h7);
        chk($sformatf("vec%0d.dst", i),  32'(dst_addr),   (tv[i].e_flit >> 25) & 32'hF);
      end
      check_model($sformatf("vec%0d.model", i));
    end

    // -------------------------------------------------------------------------
    // Ten writes interleaved with reads, wrapping both pointers; order and
    // credit count must be preserved end to end.
    // -------------------------------------------------------------------------
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_model("wrap.reset");
    credits = 0;
    for (int i = 0; i < 10; i++) begin
      do_rd = (i >= 1) && (i % 4 != 0);
      if (do_rd && !empty) got.push_back(flit_out);
      sent.push_back(32'h4000_0000 + 32'(i));
      cycle(1'b0, 1'b1, do_rd, 32'h4000_0000 + 32'(i));
      if (credit_out) credits++;
      $display("wrap %0d: write %h rd=%b -> empty=%b full=%b credit=%b",
               i, 32'h4000_0000 + 32'(i), do_rd, empty, full, credit_out);
      check_model($sformatf("wrap%0d", i));
    end
    for (int k = 0; k < 20 && !empty; k++) begin
      got.push_back(flit_out);
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      if (credit_out) credits++;
      $display("drain %0d: popped %h -> empty=%b credit=%b", k, got[got.size()-1],
               empty, credit_out);
      check_model($sformatf("drain%0d", k));
    end
    chk("drain.empty",   32'(empty),      32'd1);
    chk("wrap.count",    32'(got.size()), 32'd10);
    chk("wrap.credits",  32'(credits),    32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) chk($sformatf("wrap.order%0d", i), got[i], sent[i]);
    end

    // -------------------------------------------------------------------------
    // Randomized traffic: write-heavy phases fill the FIFO, read-heavy phases
    // drain it, with occasional resets.
    // -------------------------------------------------------------------------
    for (int c = 0; c < 600; c++) begin
      if ((c / 50) % 2 == 0) begin
        v_r  = ($urandom_range(0, 3) != 0);
        rd_r = ($urandom_range(0, 3) == 0);
      end else begin
        v_r  = ($urandom_range(0, 3) == 0);
        rd_r = ($urandom_range(0, 3) != 0);
      end
      rst_r = ($urandom_range(0, 99) == 0);
      cycle(rst_r, v_r, rd_r, $urandom);
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
